// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seg_pkg;

  localparam int SEG_W = 7;

  typedef logic [2:0] seg_val_t;

  typedef enum logic [2:0] {
    IDLE,
    BLANK,
    DRIVE,
    LATCH,
    HOLD
  } seg_scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// segintf: link between the scan controller and the shared segment decoder.
interface segintf;
  import seg_pkg::*;

  logic             en;
  seg_val_t         segin;
  logic [SEG_W-1:0] segout;

  modport master (output en, output segin, input segout);
  modport slave  (input en, input segin, output segout);
endinterface

// File: rtl/seg_tick_cnt.sv
// seg_tick_cnt: clearable up-counter; done flags that LIMIT has been reached.
module seg_tick_cnt #(
  parameter int          W     = 8,
  parameter int unsigned LIMIT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic done
);

  logic [W-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_cnt <= '0;
    else if (load)       r_cnt <= '0;
    else if (count)      r_cnt <= r_cnt + W'(1);
  end

  assign done = (r_cnt == W'(LIMIT));

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed digit scanner with a shadow/active digit buffer
// committed once per frame. Define SEG_SCAN_ZBLANK_EN for leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 1000,
  parameter int DEC_LAT  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_en,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [$clog2(NDIG)-1:0] wr_idx,
  input  seg_val_t                wr_data,
  segintf.master                  dec,
  output logic [SEG_W-1:0]        seg_o,
  output logic [NDIG-1:0]         dig_o,
  output logic                    frame_done
);

  localparam int IW = $clog2(NDIG);
  localparam int HW = $clog2(PRESCALE);

  seg_scan_state_t  r_state, w_next;
  logic [IW-1:0]    r_idx;
  seg_val_t         r_shadow [NDIG];
  seg_val_t         r_active [NDIG];
  logic [SEG_W-1:0] r_seg;
  logic [NDIG-1:0]  r_dig;
  logic             r_frame_done;

  logic w_drive_done, w_hold_done, w_last_idx, w_wrap, w_wr_fire, w_zblank;

  assign w_last_idx = (r_idx == IW'(NDIG - 1));
  assign w_wrap     = scan_en && (r_state == HOLD) && w_hold_done && w_last_idx;
  // The commit happens in the frame_done cycle, so writes are held off then.
  assign wr_ready   = ~r_frame_done;
  assign w_wr_fire  = wr_valid && wr_ready && (int'(wr_idx) < NDIG);

  seg_tick_cnt #(.W(2), .LIMIT(DEC_LAT - 1)) u_drive_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (r_state == BLANK),
    .count (r_state == DRIVE),
    .done  (w_drive_done)
  );

  seg_tick_cnt #(.W(HW), .LIMIT(PRESCALE - 2)) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (r_state == LATCH),
    .count (r_state == HOLD),
    .done  (w_hold_done)
  );

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    if (!scan_en) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = BLANK;
        BLANK:   w_next = DRIVE;
        DRIVE:   if (w_drive_done) w_next = LATCH;
        LATCH:   w_next = HOLD;
        HOLD:    if (w_hold_done) w_next = BLANK;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_frame_done <= w_wrap;
      if (scan_en && (r_state == HOLD) && w_hold_done)
        r_idx <= w_last_idx ? '0 : r_idx + IW'(1);
    end
  end

  // NOTE: the digit buffers are a handful of flops, so they are reset like any
  // other state; a large RAM would instead be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDIG; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_wr_fire) r_shadow[wr_idx] <= wr_data;
      if (r_frame_done) begin
        for (int i = 0; i < NDIG; i++) r_active[i] <= r_shadow[i];
      end
    end
  end

`ifdef SEG_SCAN_ZBLANK_EN
  // Blank when this digit and every digit above it are zero (never digit 0).
  always_comb begin
    w_zblank = (r_idx != '0);
    for (int i = 0; i < NDIG; i++) begin
      if ((i >= int'(r_idx)) && (r_active[i] != '0)) w_zblank = 1'b0;
    end
  end
`else
  assign w_zblank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= '0;
      r_dig <= '0;
    end else if (!scan_en) begin
      r_dig <= '0;
    end else begin
      case (r_state)
        LATCH: begin
          r_seg <= w_zblank ? '0 : dec.segout;
          r_dig <= NDIG'(1) << r_idx;
        end
        HOLD:    if (w_hold_done) r_dig <= '0;
        default: ;
      endcase
    end
  end

  assign dec.en     = (r_state == DRIVE);
  assign dec.segin  = (r_state == DRIVE) ? r_active[r_idx] : '0;
  assign seg_o      = r_seg;
  assign dig_o      = r_dig;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-timeline reference model under random writes,
// a table of digit patterns, and hand-written reset/commit/pause sequences.
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int NDIG     = 4;
  localparam int PRESCALE = 4;
  localparam int DEC_LAT  = 2;
  localparam int DPER     = 1 + DEC_LAT + 1 + (PRESCALE - 1);
`ifdef SEG_SCAN_ZBLANK_EN
  localparam logic [6:0] Z = 7'h00;
`else
  localparam logic [6:0] Z = 7'h3F;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             scan_en = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [1:0]       wr_idx = '0;
  seg_val_t         wr_data = '0;
  logic [SEG_W-1:0] seg_o;
  logic [NDIG-1:0]  dig_o;
  logic             frame_done;

  segintf u_dec ();

  seg_scan_ctrl #(.NDIG(NDIG), .PRESCALE(PRESCALE), .DEC_LAT(DEC_LAT)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_en    (scan_en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .dec        (u_dec),
    .seg_o      (seg_o),
    .dig_o      (dig_o),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [2:0] v);
    case (v)
      3'd0: return 7'h3F;
      3'd1: return 7'h06;
      3'd2: return 7'h5B;
      3'd3: return 7'h4F;
      3'd4: return 7'h66;
      3'd5: return 7'h6D;
      3'd6: return 7'h7D;
      default: return 7'h07;
    endcase
  endfunction

  // External decoder with DEC_LAT register stages.
  logic [6:0] r_pipe [DEC_LAT];
  always @(posedge clk) begin
    r_pipe[0] <= u_dec.en ? seg_of(u_dec.segin) : 7'h00;
    for (int i = 1; i < DEC_LAT; i++) r_pipe[i] <= r_pipe[i-1];
  end
  assign u_dec.segout = r_pipe[DEC_LAT-1];

  int n_checks = 0;
  int n_errors = 0;
  int m_shadow [NDIG];
  int m_active [NDIG];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int k);
`ifdef SEG_SCAN_ZBLANK_EN
    int hi = -1;
    for (int j = 0; j < NDIG; j++) if (m_active[j] != 0) hi = j;
    if (k != 0 && k > hi) return 7'h00;
`endif
    return seg_of(3'(m_active[k]));
  endfunction

  task automatic wait_fd();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    check("wait_frame_done", 32'(n < 200), 1);
  endtask

  task automatic wait_dig(input int k, output logic [6:0] s);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (dig_o == 4'(1 << k)) break;
    end
    check("wait_digit", 32'(n < 200), 1);
    s = seg_o;
  endtask

  task automatic wr(input int idx, input int val);
    logic acc;
    int   n = 0;
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_idx = 2'(idx); wr_data = 3'(val);
    do begin
      @(negedge clk);
      acc = wr_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    wr_valid = 1'b0;
    check("write_accept", 32'(acc), 1);
  endtask

  typedef struct packed {
    logic [NDIG-1:0][2:0] d;
    logic [NDIG-1:0][6:0] s;
  } vec_t;

  function automatic vec_t mk(input int d0, d1, d2, d3, input logic [6:0] s0, s1, s2, s3);
    vec_t v;
    v.d[0] = 3'(d0); v.d[1] = 3'(d1); v.d[2] = 3'(d2); v.d[3] = 3'(d3);
    v.s[0] = s0;     v.s[1] = s1;     v.s[2] = s2;     v.s[3] = s3;
    return v;
  endfunction

  initial begin
    vec_t       tbl [5];
    logic [6:0] s;
    int         n, o, k;
    logic [3:0] e_dig;
    logic       e_fd, e_en;

    tbl[0] = mk(3, 1, 0, 7, 7'h4F, 7'h06, 7'h3F, 7'h07);
    tbl[1] = mk(5, 0, 0, 0, 7'h6D, Z, Z, Z);
    tbl[2] = mk(0, 2, 0, 0, 7'h3F, 7'h5B, Z, Z);
    tbl[3] = mk(0, 0, 0, 0, 7'h3F, Z, Z, Z);
    tbl[4] = mk(6, 4, 2, 0, 7'h7D, 7'h66, 7'h5B, Z);
    for (int i = 0; i < NDIG; i++) begin m_shadow[i] = 0; m_active[i] = 0; end

    #1;
    check("rst_dig", dig_o, 0);
    check("rst_seg", seg_o, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_dec_en", u_dec.en, 0);
    check("rst_dec_in", u_dec.segin, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin @(negedge clk); check("idle_dig", dig_o, 0); end

    // Random writes while the timeline model predicts every cycle.
    @(posedge clk); #1;
    scan_en = 1'b1;
    for (int c = 0; c < 200; c++) begin
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_idx   = 2'($urandom_range(0, NDIG - 1));
      wr_data  = 3'($urandom_range(0, 7));
      @(negedge clk);
      e_dig = '0; e_fd = 1'b0; e_en = 1'b0; k = 0;
      if (c >= 1) begin
        n = (c - 1) / DPER;
        o = (c - 1) % DPER;
        k = n % NDIG;
        if (o >= DEC_LAT + 2) e_dig = 4'(1 << k);
        e_fd = (c > 1) && (o == 0) && (k == 0);
        e_en = (o >= 1) && (o <= DEC_LAT);
      end
      check("scan_dig", dig_o, e_dig);
      check("scan_frame_done", frame_done, e_fd);
      check("scan_wr_ready", wr_ready, !e_fd);
      check("scan_dec_en", u_dec.en, e_en);
      if (e_en) check("scan_dec_in", u_dec.segin, m_active[k]);
      if (e_dig != 0) check("scan_seg", seg_o, exp_seg(k));
      if (wr_valid && !e_fd) m_shadow[wr_idx] = wr_data;
      if (e_fd) for (int i = 0; i < NDIG; i++) m_active[i] = m_shadow[i];
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;

    // Digit patterns: load, let a commit happen, read every digit of the next frame.
    for (int t = 0; t < 5; t++) begin
      for (int d = 0; d < NDIG; d++) wr(d, tbl[t].d[d]);
      wait_fd();
      for (int d = 0; d < NDIG; d++) begin
        wait_dig(d, s);
        check($sformatf("tbl%0d_seg%0d", t, d), s, tbl[t].s[d]);
      end
    end

    // Tear-free: a mid-frame write shows only after the next commit.
    wait_dig(0, s);
    wr(2, 5);
    wait_dig(2, s);
    check("tear_old_value", s, 7'h5B);
    wait_fd();
    wait_dig(2, s);
    check("tear_new_value", s, 7'h6D);

    // Write held across the commit cycle is taken the cycle after.
    wait_fd();
    check("commit_wr_ready_low", wr_ready, 0);
    wr_valid = 1'b1; wr_idx = 2'd1; wr_data = 3'd7;
    @(posedge clk); #1;
    @(negedge clk);
    check("commit_wr_ready_back", wr_ready, 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wait_dig(1, s);
    check("commit_old_digit1", s, 7'h66);
    wait_fd();
    wait_dig(1, s);
    check("commit_new_digit1", s, 7'h07);

    // Pause during digit 2 hold, then resume at digit 2.
    wait_dig(2, s);
    scan_en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("pause_dig", dig_o, 0);
      check("pause_frame_done", frame_done, 0);
    end
    @(posedge clk); #1;
    scan_en = 1'b1;
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      if (dig_o != 0) break;
      n++;
    end
    check("resume_latency", n, DEC_LAT + 3);
    check("resume_digit", dig_o, 4'b0100);
    check("resume_seg", seg_o, 7'h6D);

    // Asynchronous reset in the middle of a hold period.
    wait_dig(3, s);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dig", dig_o, 0);
    check("async_rst_seg", seg_o, 0);
    check("async_rst_frame_done", frame_done, 0);
    check("async_rst_wr_ready", wr_ready, 1);
    check("async_rst_dec_en", u_dec.en, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_dig(0, s);
    check("post_rst_digit0", s, 7'h3F);
    wait_dig(1, s);
    check("post_rst_digit1", s, Z);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NDIG, default 4, meaning number of multiplexed digits (2..8).
REQ-002 SHALL have parameter PRESCALE, default 1000, meaning clk cycles each digit is lit (>=2).
REQ-003 SHALL have parameter DEC_LAT, default 1, meaning decoder latency in clk cycles from dec_en/dec_in to valid dec_out (1..3).
REQ-004 Clocking SHALL be one clock and reset SHALL be asynchronous active-low: port clk and port rst_n.
REQ-005 Port clk, input, 1, system clock; all state on posedge clk.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port scan_en, input, 1, enables scanning; low forces the blank-all condition.
REQ-008 Port wr_valid, input, 1, write request for the shadow digit buffer.
REQ-009 Port wr_ready, output, 1, write accepted when wr_valid and wr_ready are both high.
REQ-010 Port wr_idx, input, $clog2(NDIG), target digit index.
REQ-011 Port wr_data, input, 3, digit value 0..7.
REQ-012 Port dec_en, output, 1, enable to the shared segment decoder.
REQ-013 Port dec_in, output, 3, value presented to the decoder.
REQ-014 Port dec_out, input, 7, decoder segment pattern.
REQ-015 Port seg_o, output, 7, latched segment pattern driving the display.
REQ-016 Port dig_o, output, NDIG, one-hot active-high digit enable.
REQ-017 Port frame_done, output, 1, one-cycle pulse after the last digit's hold period.

Function
REQ-018 The FSM SHALL use states IDLE, BLANK, DRIVE, LATCH and HOLD.
REQ-019 IDLE -> BLANK when scan_en=1; any state -> IDLE when scan_en=0, with dig_o=0 in the next cycle.
REQ-020 BLANK SHALL last 1 cycle with dig_o=0 (anti-ghosting guard) and then go to DRIVE.
REQ-021 DRIVE SHALL hold dec_en=1 and dec_in=active[idx] for DEC_LAT cycles and then go to LATCH; dec_en=0 in all other states.
REQ-022 LATCH SHALL register dec_out into seg_o, set dig_o=1<<idx in the same edge, and go to HOLD.
REQ-023 HOLD SHALL count PRESCALE-1 cycles, then advance idx, wrapping from NDIG-1 to 0, and go to BLANK.
REQ-024 On the wrap from NDIG-1 to 0, frame_done SHALL pulse 1 cycle and the shadow buffer SHALL be copied to the active buffer in that cycle.
REQ-025 wr_ready SHALL be 0 in the commit cycle and 1 otherwise, so a write never collides with the commit.
REQ-026 An accepted write with wr_idx>=NDIG SHALL complete the handshake and change no state.
REQ-027 Back-to-back writes to the same index SHALL result in last-write-wins.
REQ-028 When scan_en drops mid-HOLD, the idx and shadow contents SHALL be retained, and scanning SHALL resume at the same idx.

Reset
REQ-029 While rst_n=0: state=IDLE, idx=0, prescale counter=0, dec_en=0, dec_in=0, seg_o=0, dig_o=0, frame_done=0, wr_ready=1, and shadow and active buffers all 0.

Configuration
REQ-030 With SEG_SCAN_ZBLANK_EN defined, leading-zero blanking SHALL apply: digits above the highest nonzero active digit, excluding digit 0, get seg_o=0 in LATCH while dig_o still steps normally.
REQ-031 Without SEG_SCAN_ZBLANK_EN, every digit SHALL display its decoded value.

Structure
REQ-032 Package seg_pkg SHALL hold the FSM state enum seg_scan_state_t, the typedef seg_val_t (logic [2:0]) and the constant SEG_W=7.
REQ-033 The prescale/hold counter SHALL be a sub-module named seg_tick_cnt (load, count, done).
REQ-034 The block SHALL connect to the decoder through the segintf interface (dec_en/dec_in to en/segin, dec_out from segout).

Verification
REQ-035 Reset: rst_n=0 mid-HOLD -> all outputs at reset values within the same cycle, without a clock edge.
REQ-036 Scan: NDIG=4, PRESCALE=4, digits {3,1,0,7}, scan_en=1 -> dig_o sequence 0001,0010,0100,1000 with a 1-cycle zero gap between digits, frame_done every 4*(1+DEC_LAT+1+3) cycles.
REQ-037 Tear-free: write digit 2=5 mid-frame -> seg_o for digit 2 unchanged until after the next frame_done.
REQ-038 Commit collision: wr_valid held high across the commit cycle -> wr_ready=0 that cycle, and the write is accepted the next cycle.
REQ-039 Zero blanking (macro on): digits {5,0,0,0} (idx0=5) -> digits 1..3 have seg_o=0 and digit 0 shows decoded 5; macro off -> decoded 0 shown on digits 1..3.
REQ-040 Pause: scan_en=0 during digit 2 HOLD, then 1 -> dig_o=0 during the pause, and scanning resumes with BLANK then digit 2.
